// File: rtl/mac_stream_bias_if.sv
// mac_stream_bias_if: stream bundle for the MAC block.
//   master side (feeder/consumer): drives the input beat, config and out_ready
//   slave side  (mac_stream_bias): drives in_ready, out_valid, out_data
// Ports grouped:
//   in_valid/in_ready  input beat handshake
//   act, weight        per-beat activation and per-lane weights
//   bias, k_len,       per-vector config, meaningful on the first beat only
//   shift, relu_en
//   out_valid/out_ready/out_data  result handshake and packed lane results
interface mac_stream_bias_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int N_LANES     = 4,
    parameter int K_MAX       = 768,
    parameter int SHIFT_WIDTH = 5
);
    localparam int LEN_WIDTH = $clog2(K_MAX + 1);

    logic                            in_valid;
    logic                            in_ready;
    logic [DATA_WIDTH-1:0]           act;
    logic [N_LANES*DATA_WIDTH-1:0]   weight;
    logic [N_LANES*DATA_WIDTH-1:0]   bias;
    logic [LEN_WIDTH-1:0]            k_len;
    logic [SHIFT_WIDTH-1:0]          shift;
    logic                            relu_en;
    logic                            out_valid;
    logic                            out_ready;
    logic [N_LANES*DATA_WIDTH-1:0]   out_data;

    modport master (
        output in_valid, act, weight, bias, k_len, shift, relu_en, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, act, weight, bias, k_len, shift, relu_en, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/mac_stream_bias.sv
// mac_stream_bias: streaming multiply-accumulate with per-lane bias.
// One activation element per beat is multiplied by N_LANES weights and
// accumulated; after the runtime reduction length the lane sums are
// rounded-shifted, optionally ReLU'd, saturated and presented on out_data.
// Ports:
//   clk_p  rising-edge clock
//   rst_p  asynchronous active-high reset
//   bus    mac_stream_bias_if.slave (input beats, config, result handshake)
module mac_stream_bias #(
    parameter int DATA_WIDTH  = 8,
    parameter int N_LANES     = 4,
    parameter int K_MAX       = 768,
    parameter int SHIFT_WIDTH = 5,
    parameter int ACC_WIDTH   = 2*DATA_WIDTH + $clog2(K_MAX) + 1
) (
    input  logic               clk_p,
    input  logic               rst_p,
    mac_stream_bias_if.slave   bus
);
    localparam int LEN_WIDTH = $clog2(K_MAX + 1);
    localparam int OUT_WIDTH = N_LANES * DATA_WIDTH;
    // Wide enough that the rounding constant for the largest shift never wraps.
    localparam int RND_WIDTH = ACC_WIDTH + (2**SHIFT_WIDTH);

    localparam logic signed [RND_WIDTH-1:0] RND_ONE = RND_WIDTH'(1);
    localparam logic signed [RND_WIDTH-1:0] SAT_MAX = RND_WIDTH'(2**(DATA_WIDTH-1) - 1);
    localparam logic signed [RND_WIDTH-1:0] SAT_MIN = -SAT_MAX - RND_ONE;
    localparam logic [LEN_WIDTH-1:0]        LEN_ONE = LEN_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0]        LEN_MAX = LEN_WIDTH'(K_MAX);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        OUTPUT = 2'd2
    } state_t;

    state_t                        state_r, next_state_s;
    logic signed [ACC_WIDTH-1:0]   acc_r     [N_LANES];
    logic signed [ACC_WIDTH-1:0]   acc_nxt_s [N_LANES];
    logic [LEN_WIDTH-1:0]          cnt_r, len_r, eff_len_s;
    logic [SHIFT_WIDTH-1:0]        shift_r, shift_eff_s;
    logic                          relu_r, relu_eff_s;
    logic [OUT_WIDTH-1:0]          out_data_r, out_data_s;
    logic                          out_valid_r;
    logic                          in_ready_s, beat_s, load_out_s, out_fire_s;

    // Round half toward +inf, optional ReLU, then signed saturation to DATA_WIDTH.
    function automatic logic [DATA_WIDTH-1:0] requant(
        input logic signed [ACC_WIDTH-1:0] acc_v,
        input logic [SHIFT_WIDTH-1:0]      sh_v,
        input logic                        relu_v
    );
        logic signed [RND_WIDTH-1:0] wide_v;
        logic signed [RND_WIDTH-1:0] rnd_v;
        logic [DATA_WIDTH-1:0]       res_v;
        wide_v = {{(RND_WIDTH-ACC_WIDTH){acc_v[ACC_WIDTH-1]}}, acc_v};
        if (sh_v == '0) begin
            rnd_v = wide_v;
        end else begin
            rnd_v = (wide_v + (RND_ONE <<< (sh_v - SHIFT_WIDTH'(1)))) >>> sh_v;
        end
        if (relu_v && rnd_v[RND_WIDTH-1]) begin
            rnd_v = '0;
        end else begin
            rnd_v = rnd_v;
        end
        if (rnd_v > SAT_MAX) begin
            res_v = SAT_MAX[DATA_WIDTH-1:0];
        end else if (rnd_v < SAT_MIN) begin
            res_v = SAT_MIN[DATA_WIDTH-1:0];
        end else begin
            res_v = rnd_v[DATA_WIDTH-1:0];
        end
        return res_v;
    endfunction

    // The reset gate keeps in_ready low while rst_p is asserted.
    assign in_ready_s = ~rst_p & (state_r != OUTPUT);
    assign beat_s     = bus.in_valid & in_ready_s;
    assign out_fire_s = out_valid_r & bus.out_ready;
    assign load_out_s = beat_s & (next_state_s == OUTPUT);

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;

    // Effective length and config: first beat uses the live inputs, later beats the latched copies.
    always_comb begin
        eff_len_s   = bus.k_len;
        shift_eff_s = shift_r;
        relu_eff_s  = relu_r;
        if (bus.k_len == '0) begin
            eff_len_s = LEN_ONE;
        end else if (bus.k_len > LEN_MAX) begin
            eff_len_s = LEN_MAX;
        end else begin
            eff_len_s = bus.k_len;
        end
        if (state_r == IDLE) begin
            shift_eff_s = bus.shift;
            relu_eff_s  = bus.relu_en;
        end else begin
            shift_eff_s = shift_r;
            relu_eff_s  = relu_r;
        end
    end

    // Next accumulator value per lane and the requantised result built from it.
    always_comb begin
        logic signed [DATA_WIDTH-1:0]   a_v;
        logic signed [DATA_WIDTH-1:0]   w_v;
        logic signed [DATA_WIDTH-1:0]   b_v;
        logic signed [2*DATA_WIDTH-1:0] p_v;
        logic signed [ACC_WIDTH-1:0]    base_v;
        out_data_s = '0;
        a_v        = $signed(bus.act);
        w_v        = '0;
        b_v        = '0;
        p_v        = '0;
        base_v     = '0;
        for (int l = 0; l < N_LANES; l++) begin
            acc_nxt_s[l] = '0;
            w_v    = $signed(bus.weight[l*DATA_WIDTH +: DATA_WIDTH]);
            b_v    = $signed(bus.bias[l*DATA_WIDTH +: DATA_WIDTH]);
            p_v    = a_v * w_v;
            // First beat seeds the lane with the bias instead of the stale sum.
            if (state_r == IDLE) begin
                base_v = {{(ACC_WIDTH-DATA_WIDTH){b_v[DATA_WIDTH-1]}}, b_v};
            end else begin
                base_v = acc_r[l];
            end
            acc_nxt_s[l] = base_v + {{(ACC_WIDTH-2*DATA_WIDTH){p_v[2*DATA_WIDTH-1]}}, p_v};
            out_data_s[l*DATA_WIDTH +: DATA_WIDTH] = requant(acc_nxt_s[l], shift_eff_s, relu_eff_s);
        end
    end

    // FSM state register.
    always_ff @(posedge clk_p or posedge rst_p) begin
        if (rst_p) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (beat_s) begin
                    next_state_s = (eff_len_s == LEN_ONE) ? OUTPUT : ACCUM;
                end else begin
                    next_state_s = IDLE;
                end
            end
            ACCUM: begin
                if (beat_s && (cnt_r == (len_r - LEN_ONE))) begin
                    next_state_s = OUTPUT;
                end else begin
                    next_state_s = ACCUM;
                end
            end
            OUTPUT: begin
                if (out_fire_s) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = OUTPUT;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Datapath: accumulators, beat counter, latched config and the result register.
    always_ff @(posedge clk_p or posedge rst_p) begin
        if (rst_p) begin
            for (int l = 0; l < N_LANES; l++) begin
                acc_r[l] <= '0;
            end
            cnt_r       <= '0;
            len_r       <= '0;
            shift_r     <= '0;
            relu_r      <= 1'b0;
            out_data_r  <= '0;
            out_valid_r <= 1'b0;
        end else begin
            if (beat_s) begin
                for (int l = 0; l < N_LANES; l++) begin
                    acc_r[l] <= acc_nxt_s[l];
                end
                if (state_r == IDLE) begin
                    cnt_r   <= LEN_ONE;
                    len_r   <= eff_len_s;
                    shift_r <= bus.shift;
                    relu_r  <= bus.relu_en;
                end else begin
                    cnt_r   <= cnt_r + LEN_ONE;
                end
            end
            if (load_out_s) begin
                out_data_r  <= out_data_s;
                out_valid_r <= 1'b1;
            end else if (out_fire_s) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
        end
    end
endmodule
